// File: rtl/stopwatch.sv
// Minutes:seconds stopwatch (00:00..99:59) with start/stop/clear controls.
// A prescaler turns TICKS_PER_SEC running clocks into one counted second.
module stopwatch #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  output logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] status
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  state_t        state_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    min_r;
  logic [5:0]    sec_r;
  logic          tick_s;

  // A tick occurs only on an uninterrupted running edge where the prescaler wraps.
  always_comb begin
    tick_s = 1'b0;
    if ((state_r == RUNNING) && !stop && !reset && (presc_r == PRESC_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Control FSM, prescaler and time registers; priority rst_n > reset > stop > start.
  always_ff @(posedge clk) begin
    if (!rst_n || reset) begin
      state_r <= IDLE;
      presc_r <= '0;
      min_r   <= 8'd0;
      sec_r   <= 6'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!stop && start) begin
            state_r <= RUNNING;
          end else begin
            state_r <= IDLE;
          end
        end
        RUNNING: begin
          if (stop) begin
            state_r <= PAUSED;
          end else begin
            presc_r <= tick_s ? '0 : presc_r + PW'(1);
            if (tick_s) begin
              if (sec_r == 6'd59) begin
                sec_r <= 6'd0;
                min_r <= (min_r == 8'd99) ? 8'd0 : min_r + 8'd1;
              end else begin
                sec_r <= sec_r + 6'd1;
              end
            end
          end
        end
        PAUSED: begin
          if (!stop && start) begin
            state_r <= RUNNING;
          end else begin
            state_r <= PAUSED;
          end
        end
        default: begin
          state_r <= IDLE;
          presc_r <= '0;
          min_r   <= 8'd0;
          sec_r   <= 6'd0;
        end
      endcase
    end
  end

  assign minutes = min_r;
  assign seconds = sec_r;
  assign status  = state_r;

endmodule

// File: tb/tb_stopwatch.sv
// Scoreboard bench for stopwatch: two instances (1 and 4 ticks per second)
// share stimulus; a behavioural model predicts every cycle's outputs.
module tb_stopwatch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic reset = 1'b0;
  logic [7:0] min0, min4;
  logic [5:0] sec0, sec4;
  logic [1:0] st0, st4;

  stopwatch #(.TICKS_PER_SEC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .minutes(min0), .seconds(sec0), .status(st0)
  );

  stopwatch #(.TICKS_PER_SEC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reset(reset),
    .minutes(min4), .seconds(sec4), .status(st4)
  );

  always #5 clk = ~clk;

  logic [31:0] obs;
  assign obs = {min0, sec0, st0, min4, sec4, st4};

  logic [31:0] sb[$];
  logic [31:0] exp_w;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st[2];
  int m_t[2];
  int m_p[2];
  int tps[2] = '{1, 4};

  function automatic logic [31:0] pack();
    return {8'(m_t[0] / 60), 6'(m_t[0] % 60), 2'(m_st[0]),
            8'(m_t[1] / 60), 6'(m_t[1] % 60), 2'(m_st[1])};
  endfunction

  // Drive one cycle of inputs, advance the model, queue its prediction, clock.
  task automatic drive(input logic s, input logic p, input logic r);
    start = s;
    stop  = p;
    reset = r;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || r) begin
        m_st[k] = 0; m_t[k] = 0; m_p[k] = 0;
      end else begin
        case (m_st[k])
          0: if (!p && s) m_st[k] = 1;
          1: begin
            if (p) m_st[k] = 2;
            else begin
              m_p[k]++;
              if (m_p[k] == tps[k]) begin
                m_p[k] = 0;
                m_t[k] = (m_t[k] + 1) % 6000;
              end
            end
          end
          default: if (!p && s) m_st[k] = 1;
        endcase
      end
    end
    sb.push_back(pack());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL reset_low cyc %0d: got %h want %h", i, obs, exp_w); end
      n_cmp++;
      if (obs !== 32'h0) begin n_bad++; $display("FAIL reset_zero cyc %0d: got %h want 0", i, obs); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs, exp_w); end
    end
  endtask

  task automatic test_start_run();
    drive(1'b1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== exp_w) begin n_bad++; $display("FAIL start_edge: got %h want %h", obs, exp_w); end
    for (int i = 0; i < 50; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL run cyc %0d: got %h want %h", i, obs, exp_w); end
    end
    n_cmp++;
    if ({min0, sec0, st0} !== {8'd0, 6'd50, 2'b01}) begin
      n_bad++; $display("FAIL run_end: got %0d:%0d st %b want 0:50 st 01", min0, sec0, st0);
    end
  endtask

  task automatic test_pause_resume();
    drive(1'b0, 1'b1, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== exp_w) begin n_bad++; $display("FAIL stop_edge: got %h want %h", obs, exp_w); end
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL paused cyc %0d: got %h want %h", i, obs, exp_w); end
    end
    n_cmp++;
    if ({min0, sec0, st0} !== {8'd0, 6'd50, 2'b10}) begin
      n_bad++; $display("FAIL pause_hold: got %0d:%0d st %b want 0:50 st 10", min0, sec0, st0);
    end
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      exp_w = sb.pop_front();
      if (i == 35) begin
        n_cmp++;
        if (obs !== exp_w) begin n_bad++; $display("FAIL resume_end: got %h want %h", obs, exp_w); end
      end
    end
    n_cmp++;
    if ({min0, sec0, st0} !== {8'd1, 6'd25, 2'b01}) begin
      n_bad++; $display("FAIL resume: got %0d:%0d st %b want 1:25 st 01", min0, sec0, st0);
    end
  endtask

  task automatic test_clear();
    drive(1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== exp_w) begin n_bad++; $display("FAIL clear_edge: got %h want %h", obs, exp_w); end
    n_cmp++;
    if (obs !== 32'h0) begin n_bad++; $display("FAIL clear_zero: got %h want 0", obs); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL clear_hold cyc %0d: got %h want %h", i, obs, exp_w); end
    end
    drive(1'b1, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== 32'h0 || obs !== exp_w) begin n_bad++; $display("FAIL start_reset: got %h want %h", obs, exp_w); end
  endtask

  task automatic test_rollover();
    drive(1'b1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    for (int i = 0; i < 75; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL rollover cyc %0d: got %h want %h", i, obs, exp_w); end
      if (i == 59) begin
        n_cmp++;
        if ({min0, sec0} !== {8'd1, 6'd0}) begin n_bad++; $display("FAIL minute_carry: got %0d:%0d want 1:0", min0, sec0); end
      end
    end
    n_cmp++;
    if ({min0, sec0, st0} !== {8'd1, 6'd15, 2'b01}) begin
      n_bad++; $display("FAIL rollover_end: got %0d:%0d st %b want 1:15 st 01", min0, sec0, st0);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    drive(1'b1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    for (int i = 0; i < 6000; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_w = sb.pop_front();
      n_cmp++;
      if (obs !== exp_w) begin n_bad++; $display("FAIL wrap cyc %0d: got %h want %h", i, obs, exp_w); end
      if (i == 5998) begin
        n_cmp++;
        if ({min0, sec0} !== {8'd99, 6'd59}) begin n_bad++; $display("FAIL max_time: got %0d:%0d want 99:59", min0, sec0); end
      end
    end
    n_cmp++;
    if ({min0, sec0, st0} !== {8'd0, 6'd0, 2'b01}) begin
      n_bad++; $display("FAIL wrap_end: got %0d:%0d st %b want 0:0 st 01", min0, sec0, st0);
    end
  endtask

  task automatic test_prescaler();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({sec4, st4} !== {6'd1, 2'b01}) begin n_bad++; $display("FAIL presc_phase1: got %0d st %b want 1 st 01", sec4, st4); end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (sec4 !== 6'd2) begin n_bad++; $display("FAIL presc_phase2: got %0d want 2", sec4); end
    while (sb.size() > 0) begin
      exp_w = sb.pop_front();
      if (sb.size() == 0) begin
        n_cmp++;
        if (obs !== exp_w) begin n_bad++; $display("FAIL presc_model: got %h want %h", obs, exp_w); end
      end
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 1'b1, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (st0 !== 2'b10 || obs !== exp_w) begin n_bad++; $display("FAIL both_running: got %h want %h", obs, exp_w); end
    drive(1'b1, 1'b1, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (st0 !== 2'b10 || obs !== exp_w) begin n_bad++; $display("FAIL both_paused: got %h want %h", obs, exp_w); end
    drive(1'b0, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    drive(1'b1, 1'b1, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== 32'h0 || obs !== exp_w) begin n_bad++; $display("FAIL both_idle: got %h want %h", obs, exp_w); end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      exp_w = sb.pop_front();
      if (sb.size() == 0) begin
        n_cmp++;
        if (obs !== exp_w || obs !== 32'h0) begin n_bad++; $display("FAIL rst_mid: got %h want %h", obs, exp_w); end
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    n_cmp++;
    if (obs !== 32'h0 || obs !== exp_w) begin n_bad++; $display("FAIL rst_release: got %h want %h", obs, exp_w); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_t[k] = 0; m_p[k] = 0;
    end
    #1;
    test_reset();
    test_start_run();
    test_pause_resume();
    test_clear();
    test_rollover();
    test_wrap();
    test_prescaler();
    test_simultaneous();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
